lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Initiator side of the data-port protocol: converts single load/store requests from the LSU pipeline stage into ce/addr/we/sel/wdata transactions on the data RAM port.
- Returns aligned, sign- or zero-extended load data to the pipeline.
- Provides a request/response handshake, misalignment detection and an rvalid timeout.
- Sits between the MEM stage and the data RAM / memory-mapped I/O (char-out at 32'h00020000, sim-ctrl at 32'h00020002).

Parameters:
- RVALID_TIMEOUT, 15: maximum ACCESS cycles to wait for mem_rvalid_i on a load before erroring (1..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned_i  in  1  zero-extend load (LBU/LHU)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_rdata_o  out  32  extended load data; 0 for stores/errors
- rsp_err_o  out  2  00 ok, 01 misaligned, 10 timeout
- busy_o  out  1  state != IDLE
- mem_ce_o  out  1  chip enable
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_we_o  out  1  write enable
- mem_sel_o  out  4  byte enables, bit n = byte lane n
- mem_wdata_o  out  32  lane-replicated store data
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read word (combinational from memory)

Behaviour:
- Reset: rst_i sampled on posedge clk_i. All outputs reset to 0 except req_ready_o=1. FSM goes to IDLE, timeout counter clears, any in-flight request is dropped with no response. mem_ce_o is gated by ~rst_i so no write is issued in a reset cycle.
- FSM states: IDLE, ACCESS, ACCESS2 (split only), RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch we/size/unsigned/addr/wdata.
  - Aligned request: go to ACCESS.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0): go to RESP with err=01 and no bus activity.
- ACCESS:
  - mem_ce_o=1, mem_we_o=latched we.
  - sel: byte = 1<<off; half = 2'b11<<off; word = 4'hF.
  - wdata: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
  - Store: completes this cycle; go to RESP.
  - Load: if mem_rvalid_i, capture mem_rdata_i and go to RESP. Otherwise increment the counter; when counter == RVALID_TIMEOUT, go to RESP with err=10.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - req_ready_o=0 in every state except IDLE, so at most one request is outstanding.
- Load extraction: shift the captured word right by off*8, take 8/16/32 bits, then sign-extend (req_unsigned_i=0) or zero-extend.
- Latency, accept at cycle N:
  - aligned access at N+1, response at N+2 (plus rvalid wait cycles);
  - misaligned-error response at N+1.
- Back-to-back throughput: one request per 3 cycles.
- Simultaneous events: a req_valid_i arriving while in RESP is not accepted until IDLE. mem_rvalid_i outside ACCESS/ACCESS2 is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned requests are not errors.
  - ACCESS accesses word A with the low lanes sel = size-mask<<off, truncated to 4 bits.
  - ACCESS2 accesses word A+4 (wraps mod 2^32: 32'hFFFFFFFC+4 -> 32'h00000000) with the spill-over lanes.
  - Store data is shifted across both words accordingly; load bytes are merged, then extended.
  - Response at N+3. A timeout in either access aborts with err=10.
- Undefined: ACCESS2 does not exist; misaligned requests return err=01 at N+1.

Test Plan:
- Store word 32'hDEADBEEF to 0x100, then load word 0x100 with rvalid=1 -> mem_sel_o=4'hF on the store; load rsp_rdata_o=32'hDEADBEEF, err=00, rsp_valid at accept+2.
- Store byte 8'h41 to 0x00020000 (char-out) -> mem_addr_o=0x00020000, mem_sel_o=4'b0001, mem_wdata_o=32'h41414141, a single ce/we pulse.
- Memory word 0x000080F0 at 0x200: LB 0x201 -> 32'hFFFFFF80; LBU 0x201 -> 32'h00000080; LH 0x202 -> 32'h00000000.
- LW 0x103 -> without macro: no mem_ce_o, err=01 at accept+1. With LSU_MISALIGN_SPLIT_EN, words 0x100=0x44332211 and 0x104=0x88776655 -> rdata 32'h77665544 at accept+3.
- Load with mem_rvalid_i held 0, RVALID_TIMEOUT=15 -> rsp_valid with err=10 after 15 ACCESS cycles; req_ready_o=0 throughout.
- Assert rst_i during ACCESS of a store -> no write reaches memory (mem_ce_o=0), no rsp_valid_o, FSM IDLE and req_ready_o=1 on the next cycle.

Source files
------------

// File: rtl/lsu_mem_master.sv
// LSU data-port initiator: turns single load/store requests into ce/addr/we/sel/wdata RAM transactions.
// Optional macro LSU_MISALIGN_SPLIT_EN splits misaligned accesses across two words instead of erroring.
module lsu_mem_master #(
    parameter int unsigned RVALID_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic        busy_o,
    output logic        mem_ce_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [7:0] TO_LAST = 8'(RVALID_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACCESS2, S_RESP} state_t;

    state_t      r_state, w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic [7:0]  r_cnt;
    logic [1:0]  r_err;

    logic [1:0]  w_off;
    logic [3:0]  w_mask4;
    logic [7:0]  w_sel8;
    logic [31:0] w_data_m;
    logic [63:0] w_wdata64;
    logic [31:0] w_repl;
    logic        w_req_mis;
    logic        w_lat_mis;
    logic        w_timeout;
    logic [31:0] w_sh;
    logic [31:0] w_ext;

    assign w_off     = r_addr[1:0];
    assign w_mask4   = (r_size == 2'b00) ? 4'b0001 : (r_size == 2'b01) ? 4'b0011 : 4'b1111;
    assign w_sel8    = 8'({4'b0000, w_mask4} << w_off);
    assign w_data_m  = (r_size == 2'b00) ? {24'd0, r_wdata[7:0]} :
                       (r_size == 2'b01) ? {16'd0, r_wdata[15:0]} : r_wdata;
    assign w_wdata64 = {32'd0, w_data_m} << {w_off, 3'b000};
    assign w_repl    = (r_size == 2'b00) ? {4{r_wdata[7:0]}} :
                       (r_size == 2'b01) ? {2{r_wdata[15:0]}} : r_wdata;
    assign w_req_mis = (req_size_i == 2'b01 && req_addr_i[0]) ||
                       (req_size_i[1] && req_addr_i[1:0] != 2'b00);
    assign w_lat_mis = (r_size == 2'b01 && r_addr[0]) ||
                       (r_size[1] && r_addr[1:0] != 2'b00);
    assign w_timeout = (r_cnt == TO_LAST);

    // Both captured words form one 64-bit window so split and single accesses share extraction
    assign w_sh = 32'({r_hi, r_lo} >> {w_off, 3'b000});

    always_comb begin
        w_ext = w_sh;
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_sh[7]}}, w_sh[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_sh[15]}}, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = '0;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_sel_o   = '0;
        mem_wdata_o = '0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    w_next = (w_req_mis && !SPLIT_EN) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                mem_ce_o    = ~rst_i;
                mem_we_o    = r_we & ~rst_i;
                mem_addr_o  = {r_addr[31:2], 2'b00};
                mem_sel_o   = w_sel8[3:0];
                mem_wdata_o = w_lat_mis ? w_wdata64[31:0] : w_repl;
                if (r_we || mem_rvalid_i)
                    w_next = (SPLIT_EN && w_lat_mis) ? S_ACCESS2 : S_RESP;
                else if (w_timeout)
                    w_next = S_RESP;
            end
            S_ACCESS2: begin
                mem_ce_o    = ~rst_i;
                mem_we_o    = r_we & ~rst_i;
                mem_addr_o  = {r_addr[31:2] + 30'd1, 2'b00};
                mem_sel_o   = w_sel8[7:4];
                mem_wdata_o = w_wdata64[63:32];
                if (r_we || mem_rvalid_i || w_timeout)
                    w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = r_err;
                rsp_rdata_o = (!r_we && r_err == 2'b00) ? w_ext : '0;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy_o = (r_state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_size  <= req_size_i;
                        r_uns   <= req_unsigned_i;
                        r_addr  <= req_addr_i;
                        r_wdata <= req_wdata_i;
                        r_lo    <= '0;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_err   <= (w_req_mis && !SPLIT_EN) ? 2'b01 : 2'b00;
                    end
                end
                S_ACCESS, S_ACCESS2: begin
                    if (r_we || mem_rvalid_i) begin
                        r_cnt <= '0;
                        if (!r_we) begin
                            if (r_state == S_ACCESS) r_lo <= mem_rdata_i;
                            else                     r_hi <= mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_err <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed protocol cases plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_lsu_mem_master;
    localparam int unsigned TO = 15;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;
    logic        busy_o;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    lsu_mem_master #(.RVALID_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o), .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory the DUT talks to, and the bench's own byte-level expectation of its contents
    logic [31:0] ram   [0:1023];
    logic [7:0]  ref_b [0:4095];
    bit          init_req;
    int          rv_delay;
    int          wait_ctr;
    int          n_checks;
    int          n_err;

    assign mem_rdata_i  = ram[mem_addr_o[11:2]];
    assign mem_rvalid_i = mem_ce_o && !mem_we_o && (wait_ctr >= rv_delay);

    always @(posedge clk_i) begin
        if (init_req) begin
            for (int w = 0; w < 1024; w++)
                ram[w] <= {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
        end else if (mem_ce_o && mem_we_o) begin
            for (int l = 0; l < 4; l++)
                if (mem_sel_o[l]) ram[mem_addr_o[11:2]][8*l +: 8] <= mem_wdata_o[8*l +: 8];
        end
        if (mem_ce_o && !mem_we_o) wait_ctr <= wait_ctr + 1;
        else                       wait_ctr <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
        for (int i = 0; i < nbytes(size); i++)
            ref_b[12'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_b[12'(a + 32'(i))]) << (8 * i));
        if (n == 1 && !uns && v[7])  v = v | 32'hFFFFFF00;
        if (n == 2 && !uns && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [1:0] err, output logic [31:0] rdata,
                       output logic [31:0] a0, output logic [3:0] s0, output logic [31:0] w0,
                       output int ce_n, output int we_n, output bit rdy_low);
        lat = 0; err = 0; rdata = 0; a0 = 0; s0 = 0; w0 = 0; ce_n = 0; we_n = 0; rdy_low = 1;
        @(negedge clk_i);
        chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk_i);
        #1 req_valid_i = 0;
        for (int k = 1; k <= 300 && lat == 0; k++) begin
            @(negedge clk_i);
            if (req_ready_o) rdy_low = 0;
            if (mem_ce_o) begin
                if (ce_n == 0) begin a0 = mem_addr_o; s0 = mem_sel_o; w0 = mem_wdata_o; end
                ce_n++;
                if (mem_we_o) we_n++;
            end
            if (rsp_valid_o) begin lat = k; err = rsp_err_o; rdata = rsp_rdata_o; end
        end
    endtask

    int          lat, ce_n, we_n, acc;
    logic [1:0]  err;
    logic [31:0] rdata, a0, w0;
    logic [3:0]  s0;
    bit          rdy_low;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_err = 0; rv_delay = 0;
        rst_i = 1; req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
        req_addr_i = 0; req_wdata_i = 0;
        for (int i = 0; i < 4096; i++) ref_b[i] = 8'($urandom);
        init_req = 1;
        repeat (3) @(posedge clk_i);
        #1 init_req = 0; rst_i = 0;
        @(negedge clk_i);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_ce", {31'd0, mem_ce_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err", {30'd0, rsp_err_o}, 32'd0);

        // Store word, then load it back
        txn(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        ref_store(32'h100, 2'b10, 32'hDEADBEEF);
        chk("sw_sel", {28'd0, s0}, 32'hF);
        chk("sw_addr", a0, 32'h100);
        chk("sw_wdata", w0, 32'hDEADBEEF);
        chk("sw_lat", lat, 2);
        chk("sw_ram", ram[32'h100 >> 2], 32'hDEADBEEF);
        txn(0, 2'b10, 0, 32'h100, 32'h0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_err", {30'd0, err}, 32'd0);
        chk("lw_lat", lat, 2);

        // Char-out byte store
        txn(1, 2'b00, 0, 32'h00020000, 32'h00000041, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        ref_store(32'h00020000, 2'b00, 32'h41);
        chk("sb_addr", a0, 32'h00020000);
        chk("sb_sel", {28'd0, s0}, 32'h1);
        chk("sb_wdata", w0, 32'h41414141);
        chk("sb_ce_pulses", ce_n, 1);
        chk("sb_we_pulses", we_n, 1);

        // Sign/zero extension from a known word
        txn(1, 2'b10, 0, 32'h200, 32'h000080F0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        ref_store(32'h200, 2'b10, 32'h000080F0);
        txn(0, 2'b00, 0, 32'h201, 32'h0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        chk("lb_sel", {28'd0, s0}, 32'h2);
        txn(0, 2'b00, 1, 32'h201, 32'h0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        chk("lbu_rdata", rdata, 32'h00000080);
        txn(0, 2'b01, 0, 32'h202, 32'h0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        chk("lh_rdata", rdata, 32'h00000000);
        chk("lh_sel", {28'd0, s0}, 32'hC);

        // Misaligned word load
        txn(1, 2'b10, 0, 32'h100, 32'h44332211, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        ref_store(32'h100, 2'b10, 32'h44332211);
        txn(1, 2'b10, 0, 32'h104, 32'h88776655, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        ref_store(32'h104, 2'b10, 32'h88776655);
        txn(0, 2'b10, 0, 32'h103, 32'h0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        if (SPLIT) begin
            chk("mis_rdata", rdata, 32'h77665544);
            chk("mis_err", {30'd0, err}, 32'd0);
            chk("mis_lat", lat, 3);
        end else begin
            chk("mis_ce", ce_n, 0);
            chk("mis_err", {30'd0, err}, 32'd1);
            chk("mis_lat", lat, 1);
            chk("mis_rdata", rdata, 32'd0);
        end

        // rvalid never arrives
        rv_delay = 1000;
        txn(0, 2'b10, 0, 32'h100, 32'h0, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
        chk("to_lat", lat, TO + 1);
        chk("to_err", {30'd0, err}, 32'd2);
        chk("to_rdata", rdata, 32'd0);
        chk("to_access_cycles", ce_n, TO);
        chk("to_ready_low", {31'd0, rdy_low}, 32'd1);
        rv_delay = 0;

        // Reset during the ACCESS cycle of a store
        @(negedge clk_i);
        req_valid_i = 1; req_we_i = 1; req_size_i = 2'b10; req_unsigned_i = 0;
        req_addr_i = 32'h180; req_wdata_i = 32'hCAFEF00D;
        @(posedge clk_i);
        #1 req_valid_i = 0; rst_i = 1;
        @(negedge clk_i);
        chk("rst_mid_ce", {31'd0, mem_ce_o}, 32'd0);
        chk("rst_mid_rsp", {31'd0, rsp_valid_o}, 32'd0);
        @(posedge clk_i);
        #1 rst_i = 0;
        @(negedge clk_i);
        chk("rst_mid_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_rsp2", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_mid_ram", ram[32'h180 >> 2], ref_word(32'h180));

        // Back-to-back requests with valid held high
        acc = 0;
        @(negedge clk_i);
        req_valid_i = 1; req_we_i = 0; req_size_i = 2'b10; req_addr_i = 32'h200;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk_i);
            if (req_ready_o) acc++;
        end
        req_valid_i = 0;
        chk("b2b_accepts", acc, 3);
        @(negedge clk_i);
        chk("b2b_idle", {31'd0, busy_o}, 32'd0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic        r_we_t, r_uns_t, mis;
            logic [1:0]  sz;
            logic [31:0] ad, wd, exp_rd;
            int          d, exp_lat;
            logic [1:0]  exp_err;
            r_we_t  = 1'($urandom);
            r_uns_t = 1'($urandom);
            sz      = 2'($urandom_range(0, 3));
            ad      = 32'h300 + $urandom_range(0, 32'hF7);
            wd      = $urandom;
            mis     = (sz == 2'b01 && ad[0]) || (sz[1] && ad[1:0] != 2'b00);
            d       = (!mis && !r_we_t) ? $urandom_range(0, 3) : 0;
            rv_delay = d;
            exp_err = (mis && !SPLIT) ? 2'b01 : 2'b00;
            exp_lat = (mis && !SPLIT) ? 1 : mis ? 3 : r_we_t ? 2 : 2 + d;
            exp_rd  = (r_we_t || exp_err != 0) ? 32'd0 : ref_load(ad, sz, r_uns_t);
            txn(r_we_t, sz, r_uns_t, ad, wd, lat, err, rdata, a0, s0, w0, ce_n, we_n, rdy_low);
            if (r_we_t && exp_err == 0) ref_store(ad, sz, wd);
            chk($sformatf("rnd%0d_lat", t), lat, exp_lat);
            chk($sformatf("rnd%0d_err", t), {30'd0, err}, {30'd0, exp_err});
            chk($sformatf("rnd%0d_rdata", t), rdata, exp_rd);
            chk($sformatf("rnd%0d_ram0", t), ram[ad[11:2]], ref_word(ad));
            chk($sformatf("rnd%0d_ram1", t), ram[ad[11:2] + 10'd1], ref_word(ad + 32'd4));
        end
        rv_delay = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
